// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to four-digit packed BCD converter
//
// Purpose: converts an unsigned IN_W-bit value into four packed BCD digits using
// one shift-add-3 step per clock. The output register is written only when a
// conversion completes, so a downstream multiplexed display never sees partial
// results. Inputs above 9999 are reported as OVF_CODE with ovf set.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_l       in   asynchronous active-low reset
//   start       in   conversion request, sampled only in IDLE
//   bin         in   IN_W-bit unsigned value, captured when start is accepted
//   busy        out  high in SHIFT and DONE
//   done        out  one-cycle pulse, bcd_digits/ovf valid from this cycle on
//   bcd_digits  out  [15:12] thousands .. [3:0] units
//   ovf         out  last completed conversion had bin > 9999
module bin_to_bcd_seq #(
  parameter int          IN_W     = 14,
  parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd_digits,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [IN_W-1:0] sr_q;
  logic [15:0]     acc_q;
  logic [3:0]      cnt_q;
  logic            ovf_pend_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     bcd_q;
  logic            ovf_q;

  // Nibble-adjusted scratch value, applied before every shift. Nibbles are at
  // most 9 here, so the 4-bit add never carries into the next digit.
  logic [15:0]     acc_adj_d;

  always_comb begin
    acc_adj_d = acc_q;
    for (int n = 0; n < 4; n++) begin
      if (acc_q[n*4 +: 4] >= 4'd5) begin
        acc_adj_d[n*4 +: 4] = acc_q[n*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q       <= bin;
            acc_q      <= '0;
            cnt_q      <= 4'(IN_W);
            ovf_pend_q <= (32'(bin) > 32'd9999);
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          // Bit 15 of the adjusted value is dropped; only values that are
          // already flagged as overflow can reach it.
          acc_q <= {acc_adj_d[14:0], sr_q[IN_W-1]};
          sr_q  <= {sr_q[IN_W-2:0], 1'b0};
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= ovf_pend_q ? OVF_CODE : acc_q;
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd_digits = bcd_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int IN_W = 14;

  logic            clk;
  logic            rst_l;
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  logic [15:0]     bcd_digits;
  logic            ovf;

  bin_to_bcd_seq #(.IN_W(IN_W), .OVF_CODE(16'hEEEE)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .bcd_digits (bcd_digits),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_done = 0;
  bit   b2b_mode = 1'b0;
  int   last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_l && done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done with bcd %0h, expected no done", bcd_digits);
      end else begin
        e = exp_q.pop_front();
        check("bcd_digits", int'(bcd_digits), int'(e.bcd));
        check("ovf", int'(ovf), int'(e.ovf));
      end
      if (b2b_mode && last_done_cyc >= 0) check("b2b_period", cyc - last_done_cyc, 16);
      last_done_cyc = cyc;
    end
  end

  task automatic push(input logic [15:0] b, input logic o);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Issue one start, then verify latency and busy duration.
  task automatic convert(input int v, input logic [15:0] eb, input logic eo);
    int t0;
    int busy_cnt;
    bit seen;
    push(eb, eo);
    @(negedge clk);
    start = 1'b1;
    bin   = IN_W'(v);
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        check("latency", cyc - t0, 15);
        check("busy_on_done", int'(busy), 0);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("busy_cycles", busy_cnt, 15);
  endtask

  initial begin
    int d0;
    int t0;
    start = 1'b0;
    bin   = '0;
    rst_l = 1'b0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'(bcd_digits), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    convert(1234,  16'h1234, 1'b0);
    convert(0,     16'h0000, 1'b0);
    convert(9,     16'h0009, 1'b0);
    convert(9999,  16'h9999, 1'b0);
    convert(10000, 16'hEEEE, 1'b1);
    convert(42,    16'h0042, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_bcd", int'(bcd_digits), 16'h0042);

    // Starts during SHIFT and during DONE must be ignored.
    d0 = n_done;
    push(16'h0500, 1'b0);
    @(negedge clk);
    start = 1'b1;
    bin   = IN_W'(500);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    bin   = IN_W'(777);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_dones", n_done - d0, 1);

    // Held start: three back-to-back conversions.
    d0 = n_done;
    push(16'h8191, 1'b0);
    push(16'h8191, 1'b0);
    push(16'h8191, 1'b0);
    b2b_mode = 1'b1;
    last_done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    bin   = IN_W'(8191);
    repeat (33) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (25) @(negedge clk);
    b2b_mode = 1'b0;
    check("b2b_dones", n_done - d0, 3);

    // Asynchronous reset in the middle of a conversion.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    bin   = IN_W'(4321);
    @(posedge clk);
    t0 = cyc;
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("pre_rst_busy", int'(busy), 1);
    rst_l = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_bcd", int'(bcd_digits), 0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", n_done - d0, 0);
    check("post_rst_bcd", int'(bcd_digits), 0);
    convert(4321, 16'h4321, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected finish");
    $fatal(1, "timeout");
  end

endmodule
